pipelined_add_sub: RTL and testbench
====================================

# pipelined_add_sub

Parametrised, pipelined add/subtract unit for the Beta ALU datapath, generalising the 32-bit full adder to any width and pipeline depth. Operands are split into equal slices; each pipeline stage adds one slice and passes its carry to the next. The block adds a subtract mode, a valid/enable pipeline with stall, and registered Z/V/N/C flags. It sits between the operand-select muxes and the ALU result mux.

## Interface
- WIDTH, 32, operand/result width in bits
- STAGES, 4, pipeline depth; WIDTH % STAGES == 0 and STAGES >= 1 (elaboration error otherwise); slice width S = WIDTH/STAGES
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high; overrides en
- en  in  1  pipeline advance; 0 freezes every register
- in_valid  in  1  operands on a/b/c_in/sub are valid
- sub  in  1  0: a + b + c_in; 1: a + ~b + 1 (c_in ignored)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- c_in  in  1  carry in (add mode only)
- out_valid  out  1  sum/flags valid
- sum  out  WIDTH  result, mod 2^WIDTH
- c_out  out  1  carry out of MSB (sub: 1 = no borrow)
- z  out  1  sum == 0
- v  out  1  signed overflow
- n  out  1  sum[WIDTH-1]

## Operation
- Effective B = sub ? ~b : b; effective carry-in = sub ? 1 : c_in; applied at input capture.
- Stage k (0..STAGES-1) adds slice k (bits k*S+S-1 : k*S) of A and effective B plus the carry registered from stage k-1 (stage 0 uses effective carry-in).
- Unprocessed upper slices are carried forward in skew registers; completed lower sum slices are carried forward in deskew registers, so the full result emerges aligned.
- Final stage registers sum, c_out, n = sum MSB, z = (sum == 0), v = (A[MSB] == effB[MSB]) && (sum[MSB] != A[MSB]).
- Valid bit travels with data through every stage; out_valid = valid of last stage.
- Data registers may load regardless of in_valid; outputs are only meaningful when out_valid = 1.
- STAGES = 1: single registered adder, latency 1.

## Timing
- Reset (clk edge with reset = 1): all valid bits 0, all data/carry registers 0; outputs sum = 0, c_out = 0, z = 0, v = 0, n = 0, out_valid = 0. Reset mid-stream discards all in-flight operations; none emerge afterwards.
- Input captured on a rising edge where en = 1 and reset = 0.
- Latency: result visible STAGES enabled edges after capture; with en held high, operand captured at edge t appears at outputs just after edge t+STAGES-1 (i.e. valid for the cycle following the STAGES-th edge counting capture as edge 1).
- Throughput: one operation per cycle, back-to-back, no bubbles required.
- en = 0: every register (valid bits included) holds; outputs stay constant; inputs ignored. Stall of any length, any position, loses and duplicates nothing.
- Bubbles (in_valid = 0) propagate as out_valid = 0 cycles in order.
- No combinational path from inputs to outputs.

## Test plan
- Reset then 32-bit, STAGES = 4, en = 1: a = 00000000, b = 583bd1cc, c_in = 0 -> 4 cycles later sum = 583bd1cc, c_out = 0, z = 0, v = 0, n = 0, out_valid = 1.
- Back-to-back adds: (FFFFFFFF, FFFFFFFF, c_in 1) -> FFFFFFFF, c_out 1, n 1; (e9eec208, 583bd1cc, 0) -> 422a93d4, c_out 1, v 0; (687f3b5a, 71252c6f, 1) -> d9a467ca, v 1, n 1, c_out 0; results on consecutive cycles.
- Subtract: 7FFFFFFF - FFFFFFFF -> 80000000, v 1, n 1, c_out 0; 00000005 - 00000005 -> 00000000, z 1, c_out 1, v 0.
- Stall: issue 3 ops, drop en for 5 cycles with op 2 mid-pipe, toggle inputs during stall -> outputs frozen during stall; all 3 results emerge exactly once, in order, with unchanged values.
- Reset mid-stream: issue 4 ops, assert reset 1 cycle after op 2 -> next cycle all outputs 0, out_valid 0, no stale result ever appears; new op after reset correct with normal latency.
- Parameter sweep: WIDTH = 8/STAGES = 1, WIDTH = 16/STAGES = 2, WIDTH = 64/STAGES = 8 with random a, b, sub, c_in, en, in_valid against a reference model -> bit-exact sum/flags, latency = STAGES enabled cycles.

Source files
------------

// File: rtl/pipelined_add_sub_if.sv
// Operand/result bundle for the pipelined add/subtract unit; `en` is the global
// stall, so there is no per-beat ready: a held `en` freezes both directions.
interface pipelined_add_sub_if #(
  parameter int WIDTH = 32
) ();
  logic             en;
  logic             in_valid;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             z;
  logic             v;
  logic             n;

  modport master (
    output en, in_valid, sub, a, b, c_in,
    input  out_valid, sum, c_out, z, v, n
  );

  modport slave (
    input  en, in_valid, sub, a, b, c_in,
    output out_valid, sum, c_out, z, v, n
  );
endinterface

// File: rtl/pipelined_add_sub.sv
// Sliced ripple add/sub, one WIDTH/STAGES slice per stage; latency STAGES enabled edges.
// No backpressure: en = 0 freezes every register (valid bits included), inputs ignored.
module pipelined_add_sub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic               clk,
  input logic               reset,
  pipelined_add_sub_if.slave io
);
  localparam int S   = WIDTH / STAGES;
  localparam int MSB = WIDTH - 1;
  localparam int L   = STAGES - 1;

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_add_sub: WIDTH must be a multiple of STAGES and STAGES >= 1");
  end

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] cy_q, cy_d;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic              z_q, z_d;
  logic              v_q, v_d;

  // Stage inputs: stage 0 sees the port operands, later stages the previous register.
  logic [STAGES-1:0] vld_s, cy_s;
  logic [WIDTH-1:0]  a_s   [STAGES];
  logic [WIDTH-1:0]  b_s   [STAGES];
  logic [WIDTH-1:0]  s_s   [STAGES];
  logic [S:0]        add_s [STAGES];

  always_comb begin
    vld_s = '0;
    cy_s  = '0;
    vld_d = '0;
    cy_d  = '0;
    for (int k = 0; k < STAGES; k++) begin
      a_s[k]   = '0;
      b_s[k]   = '0;
      s_s[k]   = '0;
      add_s[k] = '0;
      a_d[k]   = '0;
      b_d[k]   = '0;
      s_d[k]   = '0;
    end

    // Subtract is folded in once at capture: ~b and a forced carry-in of 1.
    vld_s[0] = io.in_valid;
    a_s[0]   = io.a;
    b_s[0]   = io.sub ? ~io.b : io.b;
    cy_s[0]  = io.sub | io.c_in;
    for (int k = 1; k < STAGES; k++) begin
      vld_s[k] = vld_q[k-1];
      a_s[k]   = a_q[k-1];
      b_s[k]   = b_q[k-1];
      cy_s[k]  = cy_q[k-1];
      s_s[k]   = s_q[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      add_s[k]          = {1'b0, a_s[k][k*S +: S]} + {1'b0, b_s[k][k*S +: S]}
                        + {{S{1'b0}}, cy_s[k]};
      s_d[k]            = s_s[k];
      s_d[k][k*S +: S]  = add_s[k][S-1:0];
      cy_d[k]           = add_s[k][S];
      a_d[k]            = a_s[k];
      b_d[k]            = b_s[k];
      vld_d[k]          = vld_s[k];
    end

    z_d = ~|s_d[L];
    v_d = (a_s[L][MSB] == b_s[L][MSB]) && (s_d[L][MSB] != a_s[L][MSB]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      cy_q  <= '0;
      z_q   <= 1'b0;
      v_q   <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (io.en) begin
      vld_q <= vld_d;
      cy_q  <= cy_d;
      z_q   <= z_d;
      v_q   <= v_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
    end
  end

  assign io.out_valid = vld_q[L];
  assign io.sum       = s_q[L];
  assign io.c_out     = cy_q[L];
  assign io.z         = z_q;
  assign io.v         = v_q;
  assign io.n         = s_q[L][MSB];
endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed checks on the 32/4 unit plus a random sweep of 32/4, 8/1, 16/2, 64/8.
module tb_pipelined_add_sub;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pipelined_add_sub_if #(.WIDTH(32)) m_if ();
  pipelined_add_sub_if #(.WIDTH(8))  s8_if ();
  pipelined_add_sub_if #(.WIDTH(16)) s16_if ();
  pipelined_add_sub_if #(.WIDTH(64)) s64_if ();

  pipelined_add_sub #(.WIDTH(32), .STAGES(4)) u_dut   (.clk(clk), .reset(reset), .io(m_if.slave));
  pipelined_add_sub #(.WIDTH(8),  .STAGES(1)) u_dut8  (.clk(clk), .reset(reset), .io(s8_if.slave));
  pipelined_add_sub #(.WIDTH(16), .STAGES(2)) u_dut16 (.clk(clk), .reset(reset), .io(s16_if.slave));
  pipelined_add_sub #(.WIDTH(64), .STAGES(8)) u_dut64 (.clk(clk), .reset(reset), .io(s64_if.slave));

  typedef struct packed {
    logic        vld;
    logic        c;
    logic        z;
    logic        v;
    logic        n;
    logic [63:0] sum;
  } res_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [68:0] got, input logic [68:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h required %h", tag, got, want);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic sub, input logic cin,
                       input logic [31:0] a, input logic [31:0] b);
    m_if.in_valid = vld;
    m_if.sub      = sub;
    m_if.c_in     = cin;
    m_if.a        = a;
    m_if.b        = b;
  endtask

  function automatic res_t exp32(input logic [31:0] s, input logic c, input logic z,
                                 input logic v, input logic n);
    res_t r;
    r.vld = 1'b1; r.c = c; r.z = z; r.v = v; r.n = n; r.sum = {32'b0, s};
    return r;
  endfunction

  function automatic res_t obs_of(input int i);
    res_t r;
    r = '0;
    case (i)
      0: begin r.vld = m_if.out_valid; r.c = m_if.c_out; r.z = m_if.z; r.v = m_if.v;
               r.n = m_if.n; r.sum = {32'b0, m_if.sum}; end
      1: begin r.vld = s8_if.out_valid; r.c = s8_if.c_out; r.z = s8_if.z; r.v = s8_if.v;
               r.n = s8_if.n; r.sum = {56'b0, s8_if.sum}; end
      2: begin r.vld = s16_if.out_valid; r.c = s16_if.c_out; r.z = s16_if.z; r.v = s16_if.v;
               r.n = s16_if.n; r.sum = {48'b0, s16_if.sum}; end
      default: begin r.vld = s64_if.out_valid; r.c = s64_if.c_out; r.z = s64_if.z;
               r.v = s64_if.v; r.n = s64_if.n; r.sum = s64_if.sum; end
    endcase
    return r;
  endfunction

  // Reference: plain wide arithmetic, independent of slicing.
  function automatic res_t model(input logic [63:0] a, input logic [63:0] b, input logic sub,
                                 input logic cin, input int w);
    res_t        r;
    logic [63:0] mask, am, eb;
    logic [64:0] full;
    mask  = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    am    = a & mask;
    eb    = (sub ? ~b : b) & mask;
    full  = {1'b0, am} + {1'b0, eb} + {64'b0, (sub | cin)};
    r.vld = 1'b1;
    r.sum = full[63:0] & mask;
    r.c   = full[w];
    r.n   = r.sum[w-1];
    r.z   = (r.sum == 64'd0);
    r.v   = (am[w-1] == eb[w-1]) && (r.sum[w-1] != am[w-1]);
    return r;
  endfunction

  res_t pipe [4][8];
  int   depth [4] = '{4, 1, 2, 8};
  int   width [4] = '{32, 8, 16, 64};

  initial begin
    res_t e1, e2, e3, got, want;
    logic [63:0] ra, rb;
    logic r_en, r_vld, r_sub, r_cin;

    m_if.en = 1'b1;
    drive(0, 0, 0, 32'h0, 32'h0);
    s8_if.en = 1'b0;  s8_if.in_valid = 1'b0;  s8_if.sub = 1'b0;  s8_if.c_in = 1'b0;
    s8_if.a = '0;     s8_if.b = '0;
    s16_if.en = 1'b0; s16_if.in_valid = 1'b0; s16_if.sub = 1'b0; s16_if.c_in = 1'b0;
    s16_if.a = '0;    s16_if.b = '0;
    s64_if.en = 1'b0; s64_if.in_valid = 1'b0; s64_if.sub = 1'b0; s64_if.c_in = 1'b0;
    s64_if.a = '0;    s64_if.b = '0;

    reset = 1'b1;
    step();
    step();
    check("reset_state", obs_of(0), '0);
    reset = 1'b0;

    drive(1, 0, 0, 32'h00000000, 32'h583bd1cc);
    step();
    drive(0, 0, 0, 32'h0, 32'h0);
    step();
    step();
    check("lat_not_early", m_if.out_valid, 1'b0);
    step();
    check("add_first", obs_of(0), exp32(32'h583bd1cc, 0, 0, 0, 0));

    drive(1, 0, 1, 32'hffffffff, 32'hffffffff); step();
    drive(1, 0, 0, 32'he9eec208, 32'h583bd1cc); step();
    drive(1, 0, 1, 32'h687f3b5a, 32'h71252c6f); step();
    drive(0, 0, 0, 32'h0, 32'h0);               step();
    check("b2b_ones", obs_of(0), exp32(32'hffffffff, 1, 0, 0, 1));
    step();
    check("b2b_carry", obs_of(0), exp32(32'h422a93d4, 1, 0, 0, 0));
    step();
    check("b2b_ovf", obs_of(0), exp32(32'hd9a467ca, 0, 0, 1, 1));
    step();
    check("b2b_bubble", m_if.out_valid, 1'b0);

    drive(1, 1, 0, 32'h7fffffff, 32'hffffffff); step();
    drive(1, 1, 1, 32'h00000005, 32'h00000005); step();
    drive(0, 0, 0, 32'h0, 32'h0); step(); step();
    check("sub_ovf", obs_of(0), exp32(32'h80000000, 0, 0, 1, 1));
    step();
    check("sub_zero", obs_of(0), exp32(32'h00000000, 1, 1, 0, 0));

    e1 = exp32(32'h00000003, 0, 0, 0, 0);
    e2 = exp32(32'h00000031, 0, 0, 0, 0);
    e3 = exp32(32'h000000ff, 1, 0, 0, 0);
    drive(1, 0, 0, 32'h00000001, 32'h00000002); step();
    drive(1, 0, 1, 32'h00000010, 32'h00000020); step();
    drive(1, 1, 0, 32'h00000100, 32'h00000001); step();
    drive(0, 0, 0, 32'h0, 32'h0);               step();
    check("stall_pre", obs_of(0), e1);
    m_if.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1, i[0], 1, $urandom, $urandom);
      step();
      check("stall_hold", obs_of(0), e1);
    end
    m_if.en = 1'b1;
    drive(0, 0, 0, 32'h0, 32'h0);
    step();
    check("stall_op2", obs_of(0), e2);
    step();
    check("stall_op3", obs_of(0), e3);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_no_dup", m_if.out_valid, 1'b0);
    end

    drive(1, 0, 0, 32'h00000001, 32'h00000001); step();
    drive(1, 0, 0, 32'h00000002, 32'h00000002); step();
    drive(1, 0, 0, 32'h00000003, 32'h00000003);
    reset = 1'b1;
    step();
    check("rst_clear", obs_of(0), '0);
    reset = 1'b0;
    drive(0, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("rst_no_stale", m_if.out_valid, 1'b0);
    end
    drive(1, 0, 0, 32'h00000005, 32'h00000003); step();
    drive(0, 0, 0, 32'h0, 32'h0); step(); step();
    check("post_rst_early", m_if.out_valid, 1'b0);
    step();
    check("post_rst_op", obs_of(0), exp32(32'h00000008, 0, 0, 0, 0));

    reset = 1'b1;
    m_if.en = 1'b1; s8_if.en = 1'b1; s16_if.en = 1'b1; s64_if.en = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 8; k++) pipe[i][k] = '0;

    for (int cyc = 0; cyc < 600; cyc++) begin
      r_en  = ($urandom_range(0, 3) != 0);
      r_vld = ($urandom_range(0, 9) < 7);
      r_sub = $urandom_range(0, 1);
      r_cin = $urandom_range(0, 1);
      ra    = {$urandom, $urandom};
      rb    = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: ra = {64{1'b1}};
        1: rb = ra;
        2: rb = {64{1'b1}};
        default: ;
      endcase
      m_if.en = r_en;   m_if.in_valid = r_vld;   m_if.sub = r_sub;   m_if.c_in = r_cin;
      m_if.a = ra[31:0];   m_if.b = rb[31:0];
      s8_if.en = r_en;  s8_if.in_valid = r_vld;  s8_if.sub = r_sub;  s8_if.c_in = r_cin;
      s8_if.a = ra[7:0];   s8_if.b = rb[7:0];
      s16_if.en = r_en; s16_if.in_valid = r_vld; s16_if.sub = r_sub; s16_if.c_in = r_cin;
      s16_if.a = ra[15:0]; s16_if.b = rb[15:0];
      s64_if.en = r_en; s64_if.in_valid = r_vld; s64_if.sub = r_sub; s64_if.c_in = r_cin;
      s64_if.a = ra;       s64_if.b = rb;
      if (r_en) begin
        for (int i = 0; i < 4; i++) begin
          for (int k = depth[i] - 1; k > 0; k--) pipe[i][k] = pipe[i][k-1];
          pipe[i][0]     = model(ra, rb, r_sub, r_cin, width[i]);
          pipe[i][0].vld = r_vld;
        end
      end
      step();
      for (int i = 0; i < 4; i++) begin
        got  = obs_of(i);
        want = pipe[i][depth[i]-1];
        check($sformatf("sweep%0d_vld", width[i]), got.vld, want.vld);
        if (want.vld) check($sformatf("sweep%0d_res", width[i]), got, want);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
